// File: rtl/bp_common_pkg.sv
// Shared memory-side NoC constants and arbiter types.
// Tiles and the link arbiter read the header length field from here.
package bp_common_pkg;

   localparam int mem_noc_flit_width_gp = 64;
   localparam int mem_noc_cord_width_gp = 10;
   localparam int mem_noc_len_width_gp  = 4;
   // The length field sits directly above the cord fields in a header flit.
   localparam int mem_noc_len_offset_gp = mem_noc_cord_width_gp;

   typedef enum logic {
      e_idle,
      e_locked
   } arb_state_e;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant over a request vector.
// The pointer moves past the granted requester only when yumi_i is high.
module bsg_arb_round_robin
   import bp_common_pkg::*;
#(
   parameter int width_p = 2,
   localparam int tag_w  = ptr_width(width_p)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   output logic [tag_w-1:0]   tag_o,
   input  logic               yumi_i
);

   logic [tag_w-1:0] ptr;
   logic [tag_w-1:0] ptr_next;
   logic             found;

   // First pass covers ptr..top, second pass wraps around to 0..ptr-1.
   always_comb begin
      grants_o = '0;
      tag_o    = '0;
      found    = 1'b0;
      for (int j = 0; j < width_p; j++) begin
         if (!found && reqs_i[j] && (j >= int'(ptr))) begin
            found       = 1'b1;
            grants_o[j] = 1'b1;
            tag_o       = tag_w'(j);
         end
      end
      for (int j = 0; j < width_p; j++) begin
         if (!found && reqs_i[j]) begin
            found       = 1'b1;
            grants_o[j] = 1'b1;
            tag_o       = tag_w'(j);
         end
      end
   end

   always_comb begin
      ptr_next = tag_o + tag_w'(1);
      if (int'(tag_o) == width_p - 1) begin
         ptr_next = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         ptr <= '0;
      end else if (yumi_i) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/bp_me_wormhole_link_arb.sv
// Packet-locked round-robin arbiter sharing one wormhole link.
// Grant is chosen on a header flit and held until the tail transfers.
module bp_me_wormhole_link_arb
   import bp_common_pkg::*;
#(
   parameter int num_req_p    = 2,
   parameter int flit_width_p = mem_noc_flit_width_gp,
   parameter int len_width_p  = mem_noc_len_width_gp,
   parameter int len_offset_p = mem_noc_len_offset_gp
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_req_p-1:0]              v_i,
   input  logic [num_req_p*flit_width_p-1:0] data_i,
   output logic [num_req_p-1:0]              ready_o,
   output logic                              v_o,
   output logic [flit_width_p-1:0]           data_o,
   input  logic                              ready_i,
   output logic [num_req_p-1:0]              grant_o,
   output logic                              busy_o
);

   localparam int tag_w = ptr_width(num_req_p);

   arb_state_e             state;
   arb_state_e             state_next;
   logic [len_width_p-1:0] cnt;
   logic [len_width_p-1:0] len;
   logic [tag_w-1:0]       owner;
   logic [tag_w-1:0]       sel;
   logic [tag_w-1:0]       arb_tag;
   logic [num_req_p-1:0]   owner_oh;
   logic [num_req_p-1:0]   reqs;
   logic [num_req_p-1:0]   arb_grants;
   logic                   locked;
   logic                   xfer;
   logic                   last;
   logic                   yumi;

   assign locked = (state == e_locked);

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
   end

   // While locked, only the owner is presented so the arbiter's tag
   // equals the owner and its pointer advances past it on the tail.
   assign reqs = locked ? (owner_oh & v_i) : v_i;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) rr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .reqs_i    (reqs),
      .grants_o  (arb_grants),
      .tag_o     (arb_tag),
      .yumi_i    (yumi)
   );

   always_comb begin
      grant_o = '0;
      sel     = locked ? owner : arb_tag;
      if (reset_n_i) begin
         grant_o = locked ? owner_oh : arb_grants;
      end
   end

   assign v_o     = |(grant_o & v_i);
   assign ready_o = grant_o & {num_req_p{ready_i}};
   assign data_o  = data_i[int'(sel)*flit_width_p +: flit_width_p];
   assign len     = data_o[len_offset_p +: len_width_p];
   assign xfer    = v_o & ready_i;
   assign last    = locked ? (cnt == len_width_p'(1)) : (len == '0);
   assign yumi    = xfer & last;
   assign busy_o  = reset_n_i & locked;

   always_comb begin
      state_next = state;
      unique case (state)
         e_idle: begin
            if (xfer && (len != '0)) begin
               state_next = e_locked;
            end
         end
         e_locked: begin
            if (yumi) begin
               state_next = e_idle;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state <= e_idle;
         cnt   <= '0;
         owner <= '0;
      end else begin
         state <= state_next;
         if (xfer) begin
            if (!locked) begin
               cnt   <= len;
               owner <= sel;
            end else begin
               cnt <= cnt - len_width_p'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bp_me_wormhole_link_arb.sv
// Directed vector bench for the packet-locked link arbiter.
module tb_bp_me_wormhole_link_arb;

   localparam int N  = 2;
   localparam int FW = 64;

   logic            clk = 1'b0;
   logic            reset_n_i;
   logic [N-1:0]    v_i;
   logic [N*FW-1:0] data_i;
   logic [N-1:0]    ready_o;
   logic            v_o;
   logic [FW-1:0]   data_o;
   logic            ready_i;
   logic [N-1:0]    grant_o;
   logic            busy_o;

   always #5 clk = ~clk;

   bp_me_wormhole_link_arb #(
      .num_req_p    (N),
      .flit_width_p (FW),
      .len_width_p  (4),
      .len_offset_p (10)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .data_i    (data_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .ready_i   (ready_i),
      .grant_o   (grant_o),
      .busy_o    (busy_o)
   );

   typedef struct {
      logic        rst_n;
      logic [1:0]  v;
      logic [63:0] d0;
      logic [63:0] d1;
      logic        rdy;
      logic        ev;
      logic [63:0] ed;
      logic [1:0]  er;
      logic [1:0]  eg;
      logic        eb;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // id in [63:60], len in [13:10], sequence tag in [9:0]
   function automatic logic [63:0] flit(input int id, input int len, input int seq);
      logic [63:0] f;
      f        = '0;
      f[63:60] = 4'(id);
      f[13:10] = 4'(len);
      f[9:0]   = 10'(seq);
      return f;
   endfunction

   task automatic add(input logic rst_n, input logic [1:0] v,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic rdy, input logic ev, input logic [63:0] ed,
                      input logic [1:0] er, input logic [1:0] eg,
                      input logic eb);
      vec_t x;
      x.rst_n = rst_n;
      x.v     = v;
      x.d0    = d0;
      x.d1    = d1;
      x.rdy   = rdy;
      x.ev    = ev;
      x.ed    = ed;
      x.er    = er;
      x.eg    = eg;
      x.eb    = eb;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] b;
      int          n;

      reset_n_i = 1'b0;
      v_i       = '0;
      data_i    = '0;
      ready_i   = 1'b0;

      // reset
      a = flit(0, 0, 0);
      b = flit(1, 0, 0);
      add(0, 2'b11, a, b, 1, 0, '0, 2'b00, 2'b00, 0);
      add(0, 2'b11, a, b, 1, 0, '0, 2'b00, 2'b00, 0);
      // single-flit packets alternate
      for (int k = 1; k <= 4; k++) begin
         a = flit(0, 0, k);
         b = flit(1, 0, k);
         if (k % 2 == 1) add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 0);
         else            add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 0);
      end
      // lock holds: req 1 len=3 while req 0 valid
      b = flit(1, 3, 5);
      add(1, 2'b10, '0, b, 1, 1, b, 2'b10, 2'b10, 0);
      for (int k = 6; k <= 8; k++) begin
         a = flit(0, 0, k);
         b = flit(1, 0, k);
         add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 1);
      end
      a = flit(0, 0, 9);
      b = flit(1, 0, 9);
      add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 0);
      // owner bubble: req 0 len=2, drops valid for 2 cycles
      a = flit(0, 2, 10);
      add(1, 2'b01, a, '0, 1, 1, a, 2'b01, 2'b01, 0);
      b = flit(1, 0, 11);
      add(1, 2'b10, '0, b, 1, 0, '0, 2'b01, 2'b01, 1);
      add(1, 2'b10, '0, b, 1, 0, '0, 2'b01, 2'b01, 1);
      a = flit(0, 0, 12);
      add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 1);
      a = flit(0, 0, 13);
      add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 1);
      a = flit(0, 0, 14);
      b = flit(1, 0, 14);
      add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 0);
      // back-pressure during a len=2 packet
      a = flit(0, 2, 20);
      add(1, 2'b01, a, '0, 1, 1, a, 2'b01, 2'b01, 0);
      a = flit(0, 0, 21);
      add(1, 2'b01, a, '0, 0, 1, a, 2'b00, 2'b01, 1);
      add(1, 2'b01, a, '0, 1, 1, a, 2'b01, 2'b01, 1);
      a = flit(0, 0, 22);
      add(1, 2'b01, a, '0, 0, 1, a, 2'b00, 2'b01, 1);
      add(1, 2'b01, a, '0, 1, 1, a, 2'b01, 2'b01, 1);
      add(1, 2'b00, '0, '0, 1, 0, '0, 2'b00, 2'b00, 0);
      a = flit(0, 0, 23);
      b = flit(1, 0, 23);
      add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 0);
      // reset at body flit 2 of a len=5 packet, pointer at 1 beforehand
      a = flit(0, 0, 29);
      add(1, 2'b01, a, '0, 1, 1, a, 2'b01, 2'b01, 0);
      a = flit(0, 0, 30);
      b = flit(1, 5, 30);
      add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 0);
      b = flit(1, 0, 31);
      add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 1);
      b = flit(1, 0, 32);
      add(0, 2'b11, a, b, 1, 0, '0, 2'b00, 2'b00, 0);
      a = flit(0, 0, 33);
      b = flit(1, 0, 33);
      add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 0);
      // maximum length: len=15 gives 16 flits
      b = flit(1, 15, 40);
      add(1, 2'b10, '0, b, 1, 1, b, 2'b10, 2'b10, 0);
      for (int k = 1; k <= 15; k++) begin
         a = flit(0, 0, 40 + k);
         b = flit(1, 0, 40 + k);
         add(1, 2'b11, a, b, 1, 1, b, 2'b10, 2'b10, 1);
      end
      a = flit(0, 0, 60);
      b = flit(1, 0, 60);
      add(1, 2'b11, a, b, 1, 1, a, 2'b01, 2'b01, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset_n_i = vecs[i].rst_n;
         v_i       = vecs[i].v;
         data_i    = {vecs[i].d1, vecs[i].d0};
         ready_i   = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d v_o", i), 64'(v_o), 64'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d data_o", i), data_o, vecs[i].ed);
         end
         chk($sformatf("vec%0d ready_o", i), 64'(ready_o), 64'(vecs[i].er));
         chk($sformatf("vec%0d grant_o", i), 64'(grant_o), 64'(vecs[i].eg));
         chk($sformatf("vec%0d busy_o", i), 64'(busy_o), 64'(vecs[i].eb));
      end

      // hand sequence: reset, then a len=1 packet must release after its tail
      @(negedge clk);
      reset_n_i = 1'b0;
      v_i       = '0;
      @(negedge clk);
      reset_n_i = 1'b1;
      v_i       = 2'b11;
      a         = flit(0, 1, 50);
      b         = flit(1, 0, 50);
      data_i    = {b, a};
      ready_i   = 1'b1;
      #1;
      chk("seq hdr grant", 64'(grant_o), 64'(2'b01));
      chk("seq hdr busy", 64'(busy_o), 64'(1'b0));
      @(negedge clk);
      a      = flit(0, 0, 51);
      data_i = {b, a};
      #1;
      chk("seq body busy", 64'(busy_o), 64'(1'b1));
      chk("seq body data", data_o, a);
      chk("seq body ready1", 64'(ready_o), 64'(2'b01));
      @(negedge clk);
      v_i = 2'b10;
      #1;
      n = 0;
      while (busy_o !== 1'b0 && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("seq release wait", 64'(n), 64'(0));
      chk("seq next grant", 64'(grant_o), 64'(2'b10));
      chk("seq next data", data_o, b);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
